// File: rtl/multi_angle_controller_pkg.sv
// Shared definitions for the multi-channel angle controller: FSM encodings,
// default Q-format constants and a signed saturation helper.
package multi_angle_controller_pkg;

    // Sparse encoding so that corrupted state values are distinguishable
    // from legal ones and can be steered back to idle.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_LATCH = 3'b001,
        ST_CALC  = 3'b010,
        ST_DONE  = 3'b100
    } state_t;

    // Default Q-format: 4 fractional bits, receiver centre at 250 raw counts.
    localparam int Q_FRAC_W     = 4;
    localparam int Q_MAP_CENTER = 250;

    // Saturate a signed value to the range of a signed 'width'-bit number.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] val,
                                                        input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        res = val;
        if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_angle_controller_if.sv
// Bundle of the start/done handshake, per-channel inputs and results.
interface multi_angle_controller_if #(
    parameter int NUM_CH = 4,
    parameter int REC_W  = 8,
    parameter int RATE_W = 16,
    parameter int GAIN_W = 16
);
    logic                       start;
    logic [NUM_CH*REC_W-1:0]    target;
    logic [NUM_CH*RATE_W-1:0]   actual;
    logic [NUM_CH-1:0]          centered;
    logic [NUM_CH-1:0]          fb_en;
    logic [NUM_CH-1:0]          fb_add;
    logic [NUM_CH*GAIN_W-1:0]   gain;
    logic [NUM_CH*RATE_W-1:0]   rate_max;
    logic [NUM_CH*RATE_W-1:0]   rate_min;
    logic [NUM_CH*RATE_W-1:0]   rate_out;
    logic [NUM_CH*RATE_W-1:0]   angle_error_out;
    logic [NUM_CH-1:0]          sat_flags;
    logic                       busy;
    logic                       done;

    modport master (
        output start, target, actual, centered, fb_en, fb_add, gain, rate_max, rate_min,
        input  rate_out, angle_error_out, sat_flags, busy, done
    );

    modport slave (
        input  start, target, actual, centered, fb_en, fb_add, gain, rate_max, rate_min,
        output rate_out, angle_error_out, sat_flags, busy, done
    );
endinterface

// File: rtl/q_sat_clamp.sv
// Signed clamp against an upper then a lower limit; the lower limit wins when
// the limits are inverted. sat_o reports that either limit was applied.
module q_sat_clamp #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] val_i,
    input  logic signed [W-1:0] max_i,
    input  logic signed [W-1:0] min_i,
    output logic signed [W-1:0] val_o,
    output logic                sat_o
);
    logic signed [W-1:0] hi_clip;
    logic                hi_hit;
    logic                lo_hit;

    // Upper clip first, then lower clip on the already-clipped value.
    always_comb begin
        hi_hit  = (val_i > max_i);
        hi_clip = hi_hit ? max_i : val_i;
        lo_hit  = (hi_clip < min_i);
        val_o   = lo_hit ? min_i : hi_clip;
        sat_o   = hi_hit | lo_hit;
    end
endmodule

// File: rtl/multi_angle_controller.sv
// N-channel angle stage: maps receiver targets to Q format, optionally folds
// in IMU feedback, scales by a per-channel gain through one shared multiplier
// and clamps to per-channel rate limits. Channels are processed serially in a
// two-stage pipeline while the FSM is in CALC.
module multi_angle_controller
    import multi_angle_controller_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int REC_W      = 8,
    parameter int RATE_W     = 16,
    parameter int FRAC_W     = Q_FRAC_W,
    parameter int GAIN_W     = 16,
    parameter int MAP_CENTER = Q_MAP_CENTER
) (
    input  logic                    us_clk,
    input  logic                    reset,
    multi_angle_controller_if.slave bus
);
    localparam int EXT_W  = RATE_W + 2;
    localparam int PROD_W = RATE_W + GAIN_W;
    localparam int IDX_W  = $clog2(NUM_CH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH);

    // Control state
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               stage_a_en;
    logic               stage_b_en;

    // Input snapshot taken in LATCH
    logic [NUM_CH*REC_W-1:0]  lat_target_q,   lat_target_d;
    logic [NUM_CH*RATE_W-1:0] lat_actual_q,   lat_actual_d;
    logic [NUM_CH-1:0]        lat_centered_q, lat_centered_d;
    logic [NUM_CH-1:0]        lat_fb_en_q,    lat_fb_en_d;
    logic [NUM_CH-1:0]        lat_fb_add_q,   lat_fb_add_d;
    logic [NUM_CH*GAIN_W-1:0] lat_gain_q,     lat_gain_d;
    logic [NUM_CH*RATE_W-1:0] lat_rate_max_q, lat_rate_max_d;
    logic [NUM_CH*RATE_W-1:0] lat_rate_min_q, lat_rate_min_d;

    // Stage A signals and the A->B pipeline register
    int                         a_ch;
    logic [REC_W-1:0]           tgt_a;
    logic signed [RATE_W-1:0]   act_a;
    logic signed [EXT_W-1:0]    mapped_a;
    logic signed [EXT_W-1:0]    act_ext_a;
    logic signed [EXT_W-1:0]    err_a;
    logic signed [RATE_W-1:0]   err_p1_q, err_p1_d;
    logic [IDX_W-1:0]           ch_p1_q,  ch_p1_d;
    logic                       vld_p1_q, vld_p1_d;

    // Stage B signals
    int                         b_ch;
    logic signed [GAIN_W-1:0]   gain_b;
    logic signed [RATE_W-1:0]   max_b;
    logic signed [RATE_W-1:0]   min_b;
    logic signed [PROD_W-1:0]   prod_b;
    logic signed [PROD_W-1:0]   shifted_b;
    logic signed [RATE_W-1:0]   shifted_sat_b;
    logic                       prod_ovf_b;
    logic signed [RATE_W-1:0]   clamp_y_b;
    logic                       clamp_hit_b;

    // Result registers
    logic [NUM_CH*RATE_W-1:0] rate_out_q,  rate_out_d;
    logic [NUM_CH*RATE_W-1:0] err_out_q,   err_out_d;
    logic [NUM_CH-1:0]        sat_flags_q, sat_flags_d;

    // FSM state and channel index register.
    always_ff @(posedge us_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: IDLE -> LATCH -> CALC (NUM_CH+1 cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LATCH;
            ST_LATCH: begin
                state_d = ST_CALC;
                idx_d   = '0;
            end
            ST_CALC: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags and pipeline stage enables.
    always_comb begin
        bus.busy   = (state_q == ST_LATCH) || (state_q == ST_CALC) || (state_q == ST_DONE);
        bus.done   = (state_q == ST_DONE);
        stage_a_en = (state_q == ST_CALC) && (idx_q < IDX_LAST);
        stage_b_en = (state_q == ST_CALC) && vld_p1_q;
    end

    // Snapshot every input in LATCH so callers may change them during CALC.
    always_comb begin
        lat_target_d   = lat_target_q;
        lat_actual_d   = lat_actual_q;
        lat_centered_d = lat_centered_q;
        lat_fb_en_d    = lat_fb_en_q;
        lat_fb_add_d   = lat_fb_add_q;
        lat_gain_d     = lat_gain_q;
        lat_rate_max_d = lat_rate_max_q;
        lat_rate_min_d = lat_rate_min_q;
        if (state_q == ST_LATCH) begin
            lat_target_d   = bus.target;
            lat_actual_d   = bus.actual;
            lat_centered_d = bus.centered;
            lat_fb_en_d    = bus.fb_en;
            lat_fb_add_d   = bus.fb_add;
            lat_gain_d     = bus.gain;
            lat_rate_max_d = bus.rate_max;
            lat_rate_min_d = bus.rate_min;
        end
    end

    // Input snapshot storage (data only, no reset).
    always_ff @(posedge us_clk) begin
        lat_target_q   <= lat_target_d;
        lat_actual_q   <= lat_actual_d;
        lat_centered_q <= lat_centered_d;
        lat_fb_en_q    <= lat_fb_en_d;
        lat_fb_add_q   <= lat_fb_add_d;
        lat_gain_q     <= lat_gain_d;
        lat_rate_max_q <= lat_rate_max_d;
        lat_rate_min_q <= lat_rate_min_d;
    end

    // ---- Stage A: map target, combine feedback, saturate error ----
    // Mapping is done two bits wider than RATE_W so the feedback sum cannot wrap.
    always_comb begin
        a_ch      = stage_a_en ? int'(idx_q) : 0;
        tgt_a     = lat_target_q[a_ch*REC_W +: REC_W];
        act_a     = lat_actual_q[a_ch*RATE_W +: RATE_W];
        act_ext_a = EXT_W'(act_a);
        if (lat_centered_q[a_ch]) begin
            mapped_a = $signed(EXT_W'({tgt_a, 1'b0})) - EXT_W'(MAP_CENTER);
        end else begin
            mapped_a = $signed(EXT_W'({tgt_a, 2'b00}));
        end
        if (!lat_fb_en_q[a_ch]) begin
            err_a = mapped_a;
        end else if (lat_fb_add_q[a_ch]) begin
            err_a = mapped_a + act_ext_a;
        end else begin
            err_a = mapped_a - act_ext_a;
        end
        err_p1_d = stage_a_en ? RATE_W'(sat_to_width(64'(err_a), RATE_W)) : err_p1_q;
        ch_p1_d  = stage_a_en ? idx_q : ch_p1_q;
        vld_p1_d = stage_a_en;
    end

    // Stage A -> B valid flag (control, reset).
    always_ff @(posedge us_clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    // Stage A -> B data (no reset).
    always_ff @(posedge us_clk) begin
        err_p1_q <= err_p1_d;
        ch_p1_q  <= ch_p1_d;
    end

    // ---- Stage B: shared multiply, rescale, clamp ----
    // A shifted product outside RATE_W always lies beyond any RATE_W limit, so
    // pre-saturating it and forcing the flag gives the same result as a wide clamp.
    always_comb begin
        b_ch          = stage_b_en ? int'(ch_p1_q) : 0;
        gain_b        = lat_gain_q[b_ch*GAIN_W +: GAIN_W];
        max_b         = lat_rate_max_q[b_ch*RATE_W +: RATE_W];
        min_b         = lat_rate_min_q[b_ch*RATE_W +: RATE_W];
        prod_b        = PROD_W'(err_p1_q) * PROD_W'(gain_b);
        shifted_b     = prod_b >>> FRAC_W;
        shifted_sat_b = RATE_W'(sat_to_width(64'(shifted_b), RATE_W));
        prod_ovf_b    = (PROD_W'(shifted_sat_b) != shifted_b);
    end

    q_sat_clamp #(
        .W (RATE_W)
    ) u_clamp (
        .val_i (shifted_sat_b),
        .max_i (max_b),
        .min_i (min_b),
        .val_o (clamp_y_b),
        .sat_o (clamp_hit_b)
    );

    // Write the finished channel's results; other channels hold.
    always_comb begin
        rate_out_d  = rate_out_q;
        err_out_d   = err_out_q;
        sat_flags_d = sat_flags_q;
        if (stage_b_en) begin
            rate_out_d[b_ch*RATE_W +: RATE_W] = clamp_y_b;
            err_out_d[b_ch*RATE_W +: RATE_W]  = err_p1_q;
            sat_flags_d[b_ch]                 = clamp_hit_b | prod_ovf_b;
        end
    end

    // Result registers, cleared by reset.
    always_ff @(posedge us_clk) begin
        if (reset) begin
            rate_out_q  <= '0;
            err_out_q   <= '0;
            sat_flags_q <= '0;
        end else begin
            rate_out_q  <= rate_out_d;
            err_out_q   <= err_out_d;
            sat_flags_q <= sat_flags_d;
        end
    end

    assign bus.rate_out        = rate_out_q;
    assign bus.angle_error_out = err_out_q;
    assign bus.sat_flags       = sat_flags_q;

endmodule

// File: tb/tb_multi_angle_controller.sv
// Scoreboard bench for multi_angle_controller (NUM_CH=4, Q12.4).
module tb_multi_angle_controller;
    localparam int NUM_CH = 4;
    localparam int REC_W  = 8;
    localparam int RATE_W = 16;
    localparam int GAIN_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_angle_controller_if #(
        .NUM_CH (NUM_CH), .REC_W (REC_W), .RATE_W (RATE_W), .GAIN_W (GAIN_W)
    ) bus ();

    multi_angle_controller #(
        .NUM_CH (NUM_CH), .REC_W (REC_W), .RATE_W (RATE_W), .FRAC_W (4),
        .GAIN_W (GAIN_W), .MAP_CENTER (250)
    ) dut (
        .us_clk (clk),
        .reset  (rst),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [NUM_CH*RATE_W-1:0] rate;
        logic [NUM_CH*RATE_W-1:0] err;
        logic [NUM_CH-1:0]        sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int cfg_tgt[NUM_CH];
    int cfg_act[NUM_CH];
    int cfg_gain[NUM_CH];
    int cfg_max[NUM_CH];
    int cfg_min[NUM_CH];
    bit cfg_cen[NUM_CH];
    bit cfg_fben[NUM_CH];
    bit cfg_fbadd[NUM_CH];

    task automatic set_defaults();
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_tgt[i] = 0;  cfg_act[i] = 0;  cfg_gain[i] = 8;
            cfg_max[i] = 400; cfg_min[i] = -400;
            cfg_cen[i] = 1'b1; cfg_fben[i] = 1'b0; cfg_fbadd[i] = 1'b0;
        end
    endtask

    task automatic randomize_cfg();
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_tgt[i]   = int'($urandom_range(0, 255));
            cfg_act[i]   = int'($urandom_range(0, 65535)) - 32768;
            cfg_gain[i]  = int'($urandom_range(0, 1023)) - 512;
            cfg_max[i]   = int'($urandom_range(0, 3000)) - 1000;
            cfg_min[i]   = int'($urandom_range(0, 3000)) - 2000;
            cfg_cen[i]   = 1'($urandom_range(0, 1));
            cfg_fben[i]  = 1'($urandom_range(0, 1));
            cfg_fbadd[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NUM_CH; i++) begin
            bus.target[i*REC_W +: REC_W]     = REC_W'(cfg_tgt[i]);
            bus.actual[i*RATE_W +: RATE_W]   = RATE_W'(cfg_act[i]);
            bus.gain[i*GAIN_W +: GAIN_W]     = GAIN_W'(cfg_gain[i]);
            bus.rate_max[i*RATE_W +: RATE_W] = RATE_W'(cfg_max[i]);
            bus.rate_min[i*RATE_W +: RATE_W] = RATE_W'(cfg_min[i]);
            bus.centered[i] = cfg_cen[i];
            bus.fb_en[i]    = cfg_fben[i];
            bus.fb_add[i]   = cfg_fbadd[i];
        end
    endtask

    task automatic scramble_inputs();
        bus.target   = $urandom;
        bus.actual   = {$urandom, $urandom};
        bus.gain     = {$urandom, $urandom};
        bus.rate_max = {$urandom, $urandom};
        bus.rate_min = {$urandom, $urandom};
        bus.centered = 4'($urandom);
        bus.fb_en    = 4'($urandom);
        bus.fb_add   = 4'($urandom);
    endtask

    // Integer reference model for one channel.
    task automatic model_ch(input int i, output logic [RATE_W-1:0] r,
                            output logic [RATE_W-1:0] e, output logic s);
        longint m, er, p, v;
        m = cfg_cen[i] ? 2 * longint'(cfg_tgt[i]) - 250 : 4 * longint'(cfg_tgt[i]);
        if (!cfg_fben[i])      er = m;
        else if (cfg_fbadd[i]) er = m + longint'(cfg_act[i]);
        else                   er = m - longint'(cfg_act[i]);
        if (er > 32767)  er = 32767;
        if (er < -32768) er = -32768;
        p = er * longint'(cfg_gain[i]);
        v = p >>> 4;
        s = 1'b0;
        if (v > longint'(cfg_max[i])) begin v = longint'(cfg_max[i]); s = 1'b1; end
        if (v < longint'(cfg_min[i])) begin v = longint'(cfg_min[i]); s = 1'b1; end
        r = v[RATE_W-1:0];
        e = er[RATE_W-1:0];
    endtask

    task automatic push_model();
        exp_t ex;
        logic [RATE_W-1:0] r, e;
        logic s;
        ex = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            model_ch(i, r, e, s);
            ex.rate[i*RATE_W +: RATE_W] = r;
            ex.err[i*RATE_W +: RATE_W]  = e;
            ex.sat[i] = s;
        end
        sb_q.push_back(ex);
    endtask

    // Returns at the falling edge one cycle after start was sampled (k=1).
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int k_now, input int limit, output int k_seen);
        k_seen = -1;
        for (int k = k_now + 1; k <= limit; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                k_seen = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        set_defaults();
        apply_inputs();
        repeat (3) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.rate_out !== '0) begin n_fail++; $display("FAIL reset_rate: got %h expected 0", bus.rate_out); end
        n_tests++; if (bus.angle_error_out !== '0) begin n_fail++; $display("FAIL reset_err: got %h expected 0", bus.angle_error_out); end
        n_tests++; if (bus.sat_flags !== '0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", bus.sat_flags); end
        rst = 1'b0;
    endtask

    task automatic test_centered();
        exp_t ex;
        int k;
        set_defaults();
        cfg_tgt[0] = 125;
        cfg_tgt[1] = 250;
        cfg_tgt[2] = 250; cfg_fben[2] = 1'b1; cfg_fbadd[2] = 1'b0; cfg_act[2] = -1000;
        cfg_tgt[3] = 0;   cfg_fben[3] = 1'b1; cfg_fbadd[3] = 1'b1; cfg_act[3] = -800;
        apply_inputs();
        sb_q.push_back('{rate: 64'hFE70_0190_007D_0000, err: 64'hFBE6_04E2_00FA_0000, sat: 4'b1100});
        pulse_start();
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL centered_busy_t1: got %b expected 1", bus.busy); end
        wait_done(1, 30, k);
        n_tests++; if (k != 7) begin n_fail++; $display("FAIL centered_done_cycle: got %0d expected 7", k); end
        ex = sb_q.pop_front();
        n_tests++; if (bus.rate_out !== ex.rate) begin n_fail++; $display("FAIL centered_rate: got %h expected %h", bus.rate_out, ex.rate); end
        n_tests++; if (bus.angle_error_out !== ex.err) begin n_fail++; $display("FAIL centered_err: got %h expected %h", bus.angle_error_out, ex.err); end
        n_tests++; if (bus.sat_flags !== ex.sat) begin n_fail++; $display("FAIL centered_sat: got %b expected %b", bus.sat_flags, ex.sat); end
        scramble_inputs();
        repeat (6) @(negedge clk);
        n_tests++; if (bus.rate_out !== ex.rate) begin n_fail++; $display("FAIL hold_rate: got %h expected %h", bus.rate_out, ex.rate); end
        n_tests++; if (bus.angle_error_out !== ex.err) begin n_fail++; $display("FAIL hold_err: got %h expected %h", bus.angle_error_out, ex.err); end
        n_tests++; if (bus.sat_flags !== ex.sat) begin n_fail++; $display("FAIL hold_sat: got %b expected %b", bus.sat_flags, ex.sat); end
    endtask

    task automatic test_unsigned_overflow();
        exp_t ex;
        int k;
        set_defaults();
        cfg_cen[0] = 1'b0; cfg_tgt[0] = 250; cfg_gain[0] = 16; cfg_max[0] = 16'h0FC0; cfg_min[0] = 0;
        cfg_tgt[1] = 0; cfg_fben[1] = 1'b1; cfg_fbadd[1] = 1'b0; cfg_act[1] = 16'h7FF0;
        cfg_cen[2] = 1'b0; cfg_tgt[2] = 10; cfg_max[2] = -100; cfg_min[2] = 100;
        cfg_tgt[3] = 126; cfg_gain[3] = -20;
        apply_inputs();
        sb_q.push_back('{rate: 64'hFFFD_0064_FE70_03E8, err: 64'h0002_0028_8000_03E8, sat: 4'b0110});
        pulse_start();
        wait_done(1, 30, k);
        n_tests++; if (k != 7) begin n_fail++; $display("FAIL unsigned_done_cycle: got %0d expected 7", k); end
        ex = sb_q.pop_front();
        n_tests++; if (bus.rate_out !== ex.rate) begin n_fail++; $display("FAIL unsigned_rate: got %h expected %h", bus.rate_out, ex.rate); end
        n_tests++; if (bus.angle_error_out !== ex.err) begin n_fail++; $display("FAIL unsigned_err: got %h expected %h", bus.angle_error_out, ex.err); end
        n_tests++; if (bus.sat_flags !== ex.sat) begin n_fail++; $display("FAIL unsigned_sat: got %b expected %b", bus.sat_flags, ex.sat); end
    endtask

    task automatic test_handshake();
        exp_t ex;
        int k;
        int bad;
        randomize_cfg();
        apply_inputs();
        push_model();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(4, 30, k);
        n_tests++; if (k != 7) begin n_fail++; $display("FAIL handshake_done_cycle: got %0d expected 7", k); end
        ex = sb_q.pop_front();
        n_tests++; if (bus.rate_out !== ex.rate) begin n_fail++; $display("FAIL handshake_rate: got %h expected %h", bus.rate_out, ex.rate); end
        n_tests++; if (bus.angle_error_out !== ex.err) begin n_fail++; $display("FAIL handshake_err: got %h expected %h", bus.angle_error_out, ex.err); end
        n_tests++; if (bus.sat_flags !== ex.sat) begin n_fail++; $display("FAIL handshake_sat: got %b expected %b", bus.sat_flags, ex.sat); end
        bad = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL ignored_start: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        exp_t ex;
        logic exp_done;
        randomize_cfg();
        apply_inputs();
        repeat (3) push_model();
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp_done = (k == 7) || (k == 15) || (k == 23);
            n_tests++;
            if (bus.done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_done k=%0d: got %b expected %b", k, bus.done, exp_done);
            end
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL b2b_extra_done k=%0d: got done expected none", k);
                end else begin
                    ex = sb_q.pop_front();
                    n_tests++; if (bus.rate_out !== ex.rate) begin n_fail++; $display("FAIL b2b_rate: got %h expected %h", bus.rate_out, ex.rate); end
                    n_tests++; if (bus.angle_error_out !== ex.err) begin n_fail++; $display("FAIL b2b_err: got %h expected %h", bus.angle_error_out, ex.err); end
                    n_tests++; if (bus.sat_flags !== ex.sat) begin n_fail++; $display("FAIL b2b_sat: got %b expected %b", bus.sat_flags, ex.sat); end
                end
            end
            if (k == 24) bus.start = 1'b0;
        end
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d left expected 0", sb_q.size()); end
        repeat (3) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        exp_t ex;
        int k;
        int bad;
        randomize_cfg();
        apply_inputs();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.rate_out !== '0) begin n_fail++; $display("FAIL midreset_rate: got %h expected 0", bus.rate_out); end
        n_tests++; if (bus.angle_error_out !== '0) begin n_fail++; $display("FAIL midreset_err: got %h expected 0", bus.angle_error_out); end
        n_tests++; if (bus.sat_flags !== '0) begin n_fail++; $display("FAIL midreset_sat: got %b expected 0", bus.sat_flags); end
        rst = 1'b0;
        bad = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad); end
        randomize_cfg();
        apply_inputs();
        push_model();
        pulse_start();
        wait_done(1, 30, k);
        n_tests++; if (k != 7) begin n_fail++; $display("FAIL postreset_done_cycle: got %0d expected 7", k); end
        ex = sb_q.pop_front();
        n_tests++; if (bus.rate_out !== ex.rate) begin n_fail++; $display("FAIL postreset_rate: got %h expected %h", bus.rate_out, ex.rate); end
        n_tests++; if (bus.angle_error_out !== ex.err) begin n_fail++; $display("FAIL postreset_err: got %h expected %h", bus.angle_error_out, ex.err); end
        n_tests++; if (bus.sat_flags !== ex.sat) begin n_fail++; $display("FAIL postreset_sat: got %b expected %b", bus.sat_flags, ex.sat); end
    endtask

    task automatic test_random_latched();
        exp_t ex;
        int k;
        for (int r = 0; r < 8; r++) begin
            randomize_cfg();
            apply_inputs();
            push_model();
            pulse_start();
            @(negedge clk);
            scramble_inputs();
            wait_done(2, 30, k);
            n_tests++; if (k != 7) begin n_fail++; $display("FAIL random%0d_done_cycle: got %0d expected 7", r, k); end
            ex = sb_q.pop_front();
            n_tests++; if (bus.rate_out !== ex.rate) begin n_fail++; $display("FAIL random%0d_rate: got %h expected %h", r, bus.rate_out, ex.rate); end
            n_tests++; if (bus.angle_error_out !== ex.err) begin n_fail++; $display("FAIL random%0d_err: got %h expected %h", r, bus.angle_error_out, ex.err); end
            n_tests++; if (bus.sat_flags !== ex.sat) begin n_fail++; $display("FAIL random%0d_sat: got %b expected %b", r, bus.sat_flags, ex.sat); end
        end
    endtask

    initial begin
        test_reset();
        test_centered();
        test_unsigned_overflow();
        test_handshake();
        test_back_to_back();
        test_reset_mid_run();
        test_random_latched();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
